tt_um_waves: RTL and testbench

//   UART-controlled multifunction waveform generator, top-level user tile of the chip.

---
 rtl/tt_um_waves.sv | 187 ++++++++++++++++++
 tb/tb_tt_um_waves.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/tt_um_waves.sv
// UART-controlled waveform generator tile: ASCII commands select the waveform and step size
// of a 16-bit phase accumulator whose top byte is mapped to an 8-bit DAC sample every clock.
module tt_um_waves #(
  parameter int CLK_HZ = 25_000_000,
  parameter int BAUD   = 115200
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       ena,
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe
);

  localparam int CLKS_PER_BIT = CLK_HZ / BAUD;
  localparam int HALF_BIT     = CLKS_PER_BIT / 2;
  localparam int CW           = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_INC   = CW'(1);

  typedef enum logic [1:0] {IDLE = 2'b00, START = 2'b01, DATA = 2'b10, STOP = 2'b11} rx_state_t;
  typedef enum logic [1:0] {SAW = 2'b00, SQUARE = 2'b01, TRIANGLE = 2'b10, SINE = 2'b11} mode_t;

  rx_state_t     rx_state;
  logic [CW-1:0] rx_cnt;
  logic [2:0]    bit_idx;
  logic [7:0]    rx_shift;
  logic [7:0]    rx_byte;
  logic          rx_valid;
  logic          rx_meta;
  logic          rx_sync;
  logic          rx_prev;
  mode_t         mode;
  logic [2:0]    freq_sel;
  logic [15:0]   acc;
  logic          unused;

  assign unused  = &{1'b0, uio_in, ui_in[7:1]};
  assign uio_out = {mode, 3'b000, freq_sel};
  assign uio_oe  = 8'hFF;

  // First quadrant of 127*sin, index 0..64 covers 0..pi/2 inclusive.
  function automatic logic [6:0] sine_quarter(input logic [6:0] idx);
    logic [6:0] q;
    case (idx)
      7'd0:  q = 7'd0;   7'd1:  q = 7'd3;   7'd2:  q = 7'd6;   7'd3:  q = 7'd9;
      7'd4:  q = 7'd12;  7'd5:  q = 7'd16;  7'd6:  q = 7'd19;  7'd7:  q = 7'd22;
      7'd8:  q = 7'd25;  7'd9:  q = 7'd28;  7'd10: q = 7'd31;  7'd11: q = 7'd34;
      7'd12: q = 7'd37;  7'd13: q = 7'd40;  7'd14: q = 7'd43;  7'd15: q = 7'd46;
      7'd16: q = 7'd49;  7'd17: q = 7'd51;  7'd18: q = 7'd54;  7'd19: q = 7'd57;
      7'd20: q = 7'd60;  7'd21: q = 7'd63;  7'd22: q = 7'd65;  7'd23: q = 7'd68;
      7'd24: q = 7'd71;  7'd25: q = 7'd73;  7'd26: q = 7'd76;  7'd27: q = 7'd78;
      7'd28: q = 7'd81;  7'd29: q = 7'd83;  7'd30: q = 7'd85;  7'd31: q = 7'd88;
      7'd32: q = 7'd90;  7'd33: q = 7'd92;  7'd34: q = 7'd94;  7'd35: q = 7'd96;
      7'd36: q = 7'd98;  7'd37: q = 7'd100; 7'd38: q = 7'd102; 7'd39: q = 7'd104;
      7'd40: q = 7'd106; 7'd41: q = 7'd107; 7'd42: q = 7'd109; 7'd43: q = 7'd111;
      7'd44: q = 7'd112; 7'd45: q = 7'd113; 7'd46: q = 7'd115; 7'd47: q = 7'd116;
      7'd48: q = 7'd117; 7'd49: q = 7'd118; 7'd50: q = 7'd120; 7'd51: q = 7'd121;
      7'd52: q = 7'd122; 7'd53: q = 7'd122; 7'd54: q = 7'd123; 7'd55: q = 7'd124;
      7'd56: q = 7'd125; 7'd57: q = 7'd125; 7'd58: q = 7'd126; 7'd59: q = 7'd126;
      7'd60: q = 7'd126; 7'd61: q = 7'd127; 7'd62: q = 7'd127; 7'd63: q = 7'd127;
      7'd64: q = 7'd127;
      default: q = 7'd0;
    endcase
    return q;
  endfunction

  // Mirror the quadrant index on odd quadrants and flip the sign on the second half-cycle.
  function automatic logic [7:0] sine_sample(input logic [7:0] p);
    logic [6:0] idx;
    logic [7:0] mag;
    idx = p[6] ? (7'd64 - {1'b0, p[5:0]}) : {1'b0, p[5:0]};
    mag = {1'b0, sine_quarter(idx)};
    return p[7] ? (8'd128 - mag) : (8'd128 + mag);
  endfunction

  function automatic logic [7:0] wave_sample(input logic [7:0] p, input mode_t m);
    logic [7:0] s;
    case (m)
      SAW:      s = p;
      SQUARE:   s = p[7] ? 8'h00 : 8'hFF;
      TRIANGLE: s = p[7] ? ~{p[6:0], 1'b0} : {p[6:0], 1'b0};
      SINE:     s = sine_sample(p);
      default:  s = 8'h00;
    endcase
    return s;
  endfunction

  // UART receiver: synchronizer, edge-triggered start, mid-bit sampling, one-cycle valid pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_meta  <= 1'b1;
      rx_sync  <= 1'b1;
      rx_prev  <= 1'b1;
      rx_state <= IDLE;
      rx_cnt   <= CNT_ZERO;
      bit_idx  <= 3'd0;
      rx_shift <= 8'h00;
      rx_byte  <= 8'h00;
      rx_valid <= 1'b0;
    end else begin
      rx_meta  <= ui_in[0];
      rx_sync  <= rx_meta;
      rx_prev  <= rx_sync;
      rx_valid <= 1'b0;
      case (rx_state)
        IDLE: begin
          rx_cnt  <= CNT_ZERO;
          bit_idx <= 3'd0;
          if (rx_prev && !rx_sync) begin
            rx_state <= START;
          end
        end
        START: begin
          if (rx_cnt == HALF_LAST) begin
            rx_cnt   <= CNT_ZERO;
            rx_state <= rx_sync ? IDLE : DATA;
          end else begin
            rx_cnt <= rx_cnt + CNT_INC;
          end
        end
        DATA: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= CNT_ZERO;
            rx_shift <= {rx_sync, rx_shift[7:1]};
            bit_idx  <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              rx_state <= STOP;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_INC;
          end
        end
        STOP: begin
          if (rx_cnt == BIT_LAST) begin
            rx_cnt   <= CNT_ZERO;
            rx_state <= IDLE;
            if (rx_sync) begin
              rx_valid <= 1'b1;
              rx_byte  <= rx_shift;
            end
          end else begin
            rx_cnt <= rx_cnt + CNT_INC;
          end
        end
        default: rx_state <= IDLE;
      endcase
    end
  end

  // Command decode; unknown bytes leave mode and frequency untouched.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode     <= SAW;
      freq_sel <= 3'd0;
    end else if (rx_valid) begin
      case (rx_byte)
        8'h53: mode <= SAW;
        8'h51: mode <= SQUARE;
        8'h54: mode <= TRIANGLE;
        8'h57: mode <= SINE;
        8'h30, 8'h31, 8'h32, 8'h33,
        8'h34, 8'h35, 8'h36, 8'h37: freq_sel <= rx_byte[2:0];
        default: begin
        end
      endcase
    end
  end

  // Phase accumulator and registered sample; mode changes never disturb the phase.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc    <= 16'h0000;
      uo_out <= 8'h00;
    end else begin
      if (ena) begin
        acc <= acc + (16'd16 << freq_sel);
      end
      uo_out <= wave_sample(acc[15:8], mode);
    end
  end

endmodule

// File: tb/tb_tt_um_waves.sv
// Directed bench for tt_um_waves: UART command frames, waveform samples against an
// independent phase/sample model, malformed frames, enable hold and mid-frame reset.
module tb_tt_um_waves;

  localparam int BIT_CLKS = 217;

  logic       clk = 1'b0;
  logic       rst;
  logic       ena;
  logic       rx;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail   = 0;

  logic [15:0] m_acc;
  logic [1:0]  m_mode;
  logic [2:0]  m_freq;
  logic [7:0]  m_out;
  logic [7:0]  m_p;

  assign ui_in  = {7'b0000000, rx};
  assign uio_in = 8'h00;

  always #20 clk = ~clk;

  tt_um_waves dut (
    .clk     (clk),
    .rst     (rst),
    .ena     (ena),
    .ui_in   (ui_in),
    .uo_out  (uo_out),
    .uio_in  (uio_in),
    .uio_out (uio_out),
    .uio_oe  (uio_oe)
  );

  function automatic logic [7:0] model_wave(input logic [7:0] p, input logic [1:0] m);
    int  v;
    real s;
    case (m)
      2'd0: v = int'(p);
      2'd1: v = (p < 8'd128) ? 255 : 0;
      2'd2: v = (p < 8'd128) ? 2 * int'(p) : 511 - 2 * int'(p);
      default: begin
        s = 127.0 * $sin(2.0 * 3.14159265358979 * real'(p) / 256.0);
        if (s >= 0.0) v = 128 + $rtoi(s + 0.5);
        else          v = 128 - $rtoi(-s + 0.5);
      end
    endcase
    return v[7:0];
  endfunction

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_fail++;
      $error("FAIL %s: observed %02h expected %02h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst) begin
      m_acc  = 16'h0000;
      m_out  = 8'h00;
      m_mode = 2'd0;
      m_freq = 3'd0;
    end else begin
      m_p   = m_acc[15:8];
      m_out = model_wave(m_p, m_mode);
      if (ena) m_acc = m_acc + (16'd16 << m_freq);
    end
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic send_bit(input logic b);
    rx = b;
    ticks(BIT_CLKS);
  endtask

  task automatic send_frame(input logic [7:0] data, input logic stop_bit);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(data[i]);
    send_bit(stop_bit);
    rx = 1'b1;
    ticks(4);
  endtask

  initial begin
    rst = 1'b1; ena = 1'b1; rx = 1'b1;
    m_acc = 16'h0000; m_mode = 2'd0; m_freq = 3'd0; m_out = 8'h00; m_p = 8'h00;

    // 1: reset, then sawtooth ramp advancing one count every 16 clocks
    ticks(2);
    check("rst_uo_out", uo_out, 8'h00);
    check("rst_uio_out", uio_out, 8'h00);
    check("uio_oe", uio_oe, 8'hFF);
    rst = 1'b0;
    for (int k = 1; k <= 48; k++) begin
      tick();
      check("saw_ramp", uo_out, m_out);
      if (k == 16) check("saw_k16", uo_out, 8'd0);
      if (k == 17) check("saw_k17", uo_out, 8'd1);
      if (k == 48) check("saw_k48", uo_out, 8'd2);
    end
    ena = 1'b0;
    check("saw_status", uio_out, 8'h00);

    // 2: square wave, phase 0x03 -> high, run across the half-cycle boundary
    send_frame(8'h51, 1'b1);
    m_mode = 2'd1;
    ticks(2);
    check("sq_status", uio_out, 8'h40);
    check("sq_held_high", uo_out, 8'hFF);
    ena = 1'b1;
    for (int k = 0; k < 2128; k++) begin
      tick();
      check("sq_run", uo_out, m_out);
    end
    ena = 1'b0;
    check("sq_low", uo_out, 8'h00);

    // 3: fastest step and sine, phase aligned to multiples of 8
    send_frame(8'h37, 1'b1);
    send_frame(8'h57, 1'b1);
    m_freq = 3'd7; m_mode = 2'd3;
    ticks(2);
    check("sine_status", uio_out, 8'hC7);
    check("sine_held", uo_out, m_out);
    ena = 1'b1;
    for (int k = 0; k < 64; k++) begin
      tick();
      check("sine_run", uo_out, m_out);
      if (m_p == 8'd64)  check("sine_p64", uo_out, 8'd255);
      if (m_p == 8'd192) check("sine_p192", uo_out, 8'd1);
      if (m_p == 8'd128) check("sine_p128", uo_out, 8'd128);
      if (m_p == 8'd0)   check("sine_p0", uo_out, 8'd128);
    end
    ena = 1'b0;

    // 4: triangle, then step 256 so every phase value is visited
    send_frame(8'h54, 1'b1);
    m_mode = 2'd2;
    ticks(2);
    check("tri_status", uio_out, 8'h87);
    check("tri_p88", uo_out, 8'hEF);
    send_frame(8'h34, 1'b1);
    m_freq = 3'd4;
    ticks(2);
    check("tri_f4_status", uio_out, 8'h84);
    ena = 1'b1;
    for (int k = 0; k < 260; k++) begin
      tick();
      check("tri_run", uo_out, m_out);
      if (m_p == 8'h40) check("tri_p40", uo_out, 8'h80);
      if (m_p == 8'hC0) check("tri_pC0", uo_out, 8'h7F);
      if (m_p == 8'h7F) check("tri_peak", uo_out, 8'hFE);
    end
    ena = 1'b0;

    // 5: ignored byte, framing error, short glitch; receiver still works afterwards
    send_frame(8'h41, 1'b1);
    ticks(2);
    check("ignore_A", uio_out, 8'h84);
    send_frame(8'h30, 1'b0);
    ticks(2);
    check("frame_err", uio_out, 8'h84);
    rx = 1'b0;
    ticks(2);
    rx = 1'b1;
    ticks(300);
    check("glitch", uio_out, 8'h84);
    check("glitch_wave", uo_out, m_out);
    send_frame(8'h32, 1'b1);
    m_freq = 3'd2;
    ticks(2);
    check("freq2_status", uio_out, 8'h82);
    send_frame(8'h53, 1'b1);
    m_mode = 2'd0;
    ticks(2);
    check("saw_cmd_status", uio_out, 8'h02);
    check("saw_cmd_p8c", uo_out, 8'h8C);

    // 6: enable low holds the sample; reset mid-frame clears everything
    for (int k = 0; k < 100; k++) begin
      tick();
      check("hold_model", uo_out, m_out);
    end
    check("hold_p8c", uo_out, 8'h8C);
    send_bit(1'b0);
    rx = 1'b1;
    ticks(100);
    rst = 1'b1;
    tick();
    check("midrst_uo_out", uo_out, 8'h00);
    check("midrst_uio_out", uio_out, 8'h00);
    check("midrst_uio_oe", uio_oe, 8'hFF);
    rst = 1'b0;
    ena = 1'b1;
    send_frame(8'h57, 1'b1);
    m_mode = 2'd3;
    ticks(2);
    check("post_rst_status", uio_out, 8'hC0);
    for (int k = 0; k < 8; k++) begin
      tick();
      check("post_rst_sine", uo_out, m_out);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
